// File: rtl/microwave_oven_controller.sv
// Microwave oven front-panel controller: keypad time entry, whole-second
// countdown while the magnetron is on, and three seven-segment digit drivers.
`timescale 1ns/1ps
module microwave_oven_controller #(
    parameter int CLK_HZ = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [6:0] sec_ones,
    output logic [6:0] sec_tens,
    output logic [6:0] mins,
    output logic       mag_on
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [3:0]    dig_m;
    logic [3:0]    dig_t;
    logic [3:0]    dig_o;
    logic [9:0]    prev_keypad;
    logic [PW-1:0] prescale;

    logic          key_onehot;
    logic          key_accept;
    logic [3:0]    key_digit;
    logic          time_zero;
    logic          hold_req;
    logic          start_ok;
    logic          tick;
    logic [11:0]   dec_time;
    logic          dec_zero;

    // Seven-segment code, bit0 = a ... bit6 = g, active high
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // One-second decrement of M:T:O with minute borrow reloading T to 5
    function automatic logic [11:0] decrement(input logic [11:0] v);
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        {m, t, o} = v;
        if (o != 4'd0) begin
            o = o - 4'd1;
        end else if (t != 4'd0) begin
            t = t - 4'd1;
            o = 4'd9;
        end else if (m != 4'd0) begin
            m = m - 4'd1;
            t = 4'd5;
            o = 4'd9;
        end
        return {m, t, o};
    endfunction

    // Index of the single set key (only meaningful when keypad is one-hot)
    function automatic logic [3:0] key_index(input logic [9:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) d = 4'(i);
        end
        return d;
    endfunction

    assign key_onehot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    assign key_accept = key_onehot && (prev_keypad == 10'd0);
    assign key_digit  = key_index(keypad);
    assign time_zero  = ({dig_m, dig_t, dig_o} == 12'd0);
    assign hold_req   = !door_closed || !stopn;
    assign start_ok   = !startn && !hold_req && !time_zero;
    assign tick       = (prescale == PW'(CLK_HZ - 1));
    assign dec_time   = decrement({dig_m, dig_t, dig_o});
    assign dec_zero   = (dec_time == 12'd0);

    // State register; mag_on registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            mag_on <= 1'b0;
        end else begin
            state  <= next_state;
            mag_on <= (next_state == COOK);
        end
    end

    // Next-state logic: clear beats stop/door, which beat start
    always_comb begin
        next_state = state;
        if (!clearn) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) next_state = COOK;
                COOK: begin
                    if (hold_req)             next_state = PAUSED;
                    else if (tick && dec_zero) next_state = IDLE;
                end
                PAUSED:  if (start_ok) next_state = COOK;
                default: next_state = IDLE;
            endcase
        end
    end

    // Display decode follows the time register in every state
    always_comb begin
        mins     = seg7(dig_m);
        sec_tens = seg7(dig_t);
        sec_ones = seg7(dig_o);
    end

    // Seconds prescaler: runs only while staying in COOK, zero otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            prescale <= '0;
        end else if (state == COOK && next_state == COOK) begin
            prescale <= tick ? '0 : prescale + PW'(1);
        end else begin
            prescale <= '0;
        end
    end

    // Previous keypad value for press-edge detection
    always_ff @(posedge clock) begin
        if (reset) prev_keypad <= 10'd0;
        else       prev_keypad <= keypad;
    end

    // Time register: clear, keypad shift-in while idle, countdown while cooking
    always_ff @(posedge clock) begin
        if (reset || !clearn) begin
            dig_m <= 4'd0;
            dig_t <= 4'd0;
            dig_o <= 4'd0;
        end else if (state == IDLE && key_accept) begin
            dig_m <= dig_t;
            dig_t <= dig_o;
            dig_o <= key_digit;
        end else if (state == COOK && !hold_req && tick) begin
            {dig_m, dig_t, dig_o} <= dec_time;
        end
    end

endmodule

// File: tb/tb_microwave_oven_controller.sv
// Bench for microwave_oven_controller: directed front-panel scenarios followed
// by random panel activity, all scored against a seconds-count reference model.
`timescale 1ns/1ps
module tb_microwave_oven_controller;

    localparam int CLK_HZ = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] keypad = 10'd0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       clearn = 1'b1;
    logic       door_closed = 1'b1;
    logic [6:0] sec_ones;
    logic [6:0] sec_tens;
    logic [6:0] mins;
    logic       mag_on;

    int vectors = 0;
    int miscompares = 0;
    logic [21:0] exp_q[$];

    // Reference model: time as a plain 3-digit decimal number, mode 0/1/2 = idle/cook/paused
    int         m_num = 0;
    int         m_mode = 0;
    int         m_elapsed = 0;
    logic [9:0] m_last = 10'd0;

    microwave_oven_controller #(.CLK_HZ(CLK_HZ)) dut (
        .clock(clock),
        .reset(reset),
        .keypad(keypad),
        .startn(startn),
        .stopn(stopn),
        .clearn(clearn),
        .door_closed(door_closed),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .mins(mins),
        .mag_on(mag_on)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_step();
        bit start_ok;
        bit accept;
        int d;
        if (reset) begin
            m_num = 0;
            m_mode = 0;
            m_elapsed = 0;
            m_last = 10'd0;
        end else begin
            accept = ($countones(keypad) == 1) && (m_last == 10'd0);
            start_ok = !startn && stopn && door_closed && (m_num != 0);
            d = 0;
            for (int i = 0; i < 10; i++) if (keypad[i]) d = i;
            if (!clearn) begin
                m_num = 0;
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (accept) m_num = (m_num % 100) * 10 + d;
                if (start_ok) begin
                    m_mode = 1;
                    m_elapsed = 0;
                end
            end else if (m_mode == 1) begin
                if (!door_closed || !stopn) begin
                    m_mode = 2;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == CLK_HZ) begin
                        m_elapsed = 0;
                        m_num = (m_num % 100 == 0) ? m_num - 41 : m_num - 1;
                        if (m_num == 0) m_mode = 0;
                    end
                end
            end else if (start_ok) begin
                m_mode = 1;
                m_elapsed = 0;
            end
            m_last = keypad;
        end
        exp_q.push_back({seg_of(m_num / 100), seg_of((m_num / 10) % 10),
                         seg_of(m_num % 10), (m_mode == 1)});
    endtask

    // Apply current inputs for n edges; called and returns at a falling edge
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clock);
        end
    endtask

    task automatic press(input int k);
        keypad = 10'd1 << k;
        run(50);
        keypad = 10'd0;
        run(50);
    endtask

    task automatic check_now(input string name, input logic [6:0] em, input logic [6:0] et,
                             input logic [6:0] eo, input logic emag);
        vectors++;
        if ({mins, sec_tens, sec_ones, mag_on} !== {em, et, eo, emag}) begin
            miscompares++;
            $display("FAIL %s: got m=%h t=%h o=%h mag=%b, want m=%h t=%h o=%h mag=%b",
                     name, mins, sec_tens, sec_ones, mag_on, em, et, eo, emag);
        end
    endtask

    // Scoreboard monitor: one expected entry per clock edge
    initial begin
        logic [21:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({mins, sec_tens, sec_ones, mag_on} !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: got %h want %h", $time,
                             {mins, sec_tens, sec_ones, mag_on}, e);
                end
            end
        end
    end

    initial begin
        int r;
        @(negedge clock);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        check_now("reset", 7'h3F, 7'h3F, 7'h3F, 1'b0);

        press(1); press(4); press(0);
        check_now("entry_140", 7'h06, 7'h66, 7'h3F, 1'b0);
        keypad = 10'b10_0001_0000;
        run(50);
        keypad = 10'd0;
        run(50);
        check_now("invalid_key", 7'h06, 7'h66, 7'h3F, 1'b0);

        startn = 1'b0;
        run(1);
        check_now("start_mag", 7'h06, 7'h66, 7'h3F, 1'b1);
        run(1000);
        check_now("count_130", 7'h06, 7'h4F, 7'h3F, 1'b1);

        stopn = 1'b0;
        run(500);
        check_now("paused_130", 7'h06, 7'h4F, 7'h3F, 1'b0);
        stopn = 1'b1;
        run(100);
        check_now("resume_130", 7'h06, 7'h4F, 7'h3F, 1'b1);
        run(1);
        check_now("resume_129", 7'h06, 7'h5B, 7'h6F, 1'b1);

        startn = 1'b1;
        clearn = 1'b0;
        run(20);
        check_now("clear", 7'h3F, 7'h3F, 7'h3F, 1'b0);
        clearn = 1'b1;
        run(5);
        press(1); press(4); press(0);
        check_now("reentry_140", 7'h06, 7'h66, 7'h3F, 1'b0);
        startn = 1'b0;
        run(1);
        check_now("restart", 7'h06, 7'h66, 7'h3F, 1'b1);
        run(100);
        check_now("restart_139", 7'h06, 7'h4F, 7'h6F, 1'b1);

        startn = 1'b1;
        clearn = 1'b0;
        run(2);
        clearn = 1'b1;
        press(2);
        check_now("entry_002", 7'h3F, 7'h3F, 7'h5B, 1'b0);
        startn = 1'b0;
        run(1);
        run(199);
        check_now("expiry_001", 7'h3F, 7'h3F, 7'h06, 1'b1);
        run(1);
        check_now("expiry_000", 7'h3F, 7'h3F, 7'h3F, 1'b0);
        run(20);
        check_now("start_zero", 7'h3F, 7'h3F, 7'h3F, 1'b0);

        startn = 1'b1;
        press(5);
        door_closed = 1'b0;
        startn = 1'b0;
        run(10);
        check_now("door_open_start", 7'h3F, 7'h3F, 7'h6D, 1'b0);
        door_closed = 1'b1;
        run(1);
        check_now("door_close_start", 7'h3F, 7'h3F, 7'h6D, 1'b1);
        run(150);
        check_now("door_count", 7'h3F, 7'h3F, 7'h66, 1'b1);
        door_closed = 1'b0;
        run(300);
        check_now("door_pause", 7'h3F, 7'h3F, 7'h66, 1'b0);
        startn = 1'b1;
        run(10);
        door_closed = 1'b1;
        run(10);
        check_now("door_held", 7'h3F, 7'h3F, 7'h66, 1'b0);

        for (int s = 0; s < 400; s++) begin
            r = int'($urandom % 10);
            if (r < 6)      keypad = 10'd0;
            else if (r < 9) keypad = 10'd1 << $urandom_range(0, 9);
            else            keypad = 10'($urandom);
            startn      = ($urandom % 10) >= 4;
            stopn       = ($urandom % 10) != 0;
            clearn      = ($urandom % 30) != 0;
            door_closed = ($urandom % 10) != 0;
            reset       = ($urandom % 100) == 0;
            run(int'($urandom_range(1, 60)));
        end
        reset = 1'b0;
        run(5);

        @(posedge clock);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/microwave_oven_controller.md
# microwave_oven_controller

Top-level control block of the microwave oven: it captures a cooking time from a one-hot decimal keypad, counts the time down in whole seconds while the magnetron is on, and drives three seven-segment digits (minutes, tens of seconds, ones of seconds). Start, stop and clear are active-low push-button levels, and a door-closed interlock gates cooking. The block sits directly between the front-panel inputs and the display/magnetron drivers.

## Interface
- CLK_HZ, 100: clock cycles per second; sets the seconds prescaler.
- clock  in  1  system clock; all logic on its rising edge (100 Hz nominal).
- reset  in  1  synchronous, active-high reset.
- keypad  in  10  one-hot digit keys; bit n = digit n.
- startn  in  1  start request, active low, level-sensitive.
- stopn  in  1  pause request, active low, level-sensitive.
- clearn  in  1  clear request, active low, level-sensitive.
- door_closed  in  1  1 = door closed.
- sec_ones  out  7  seven-segment code for the seconds-ones digit.
- sec_tens  out  7  seven-segment code for the seconds-tens digit.
- mins  out  7  seven-segment code for the minutes digit.
- mag_on  out  1  magnetron enable, registered.

All inputs are synchronous to `clock`. No internal synchronizers.

## Operation
- **Time register:** three BCD digits M, T, O, each 0–9.
- **States:**
  - IDLE: entry allowed.
  - COOK: mag_on = 1.
  - PAUSED: time held, entry ignored.
- **Keypad entry (IDLE only):**
  - A key is accepted on the first cycle keypad is exactly one-hot while the registered previous keypad value was all-zero. This gives one digit per press.
  - Zero or multi-hot patterns are ignored, e.g. 10'b10_0001_0000 is dropped.
  - Accepted digit d shifts in from the right: M←T, T←O, O←d. The old M is discarded.
  - Keys 1, 4, 0 give 1:40.
- **Priority each cycle (highest first):** reset, clearn==0, (door_closed==0 or stopn==0), startn==0.
- **reset:**
  - Time = 0:00, state = IDLE, mag_on = 0, previous-keypad register = 0.
- **clearn==0 (any state):**
  - Time = 0:00, state = IDLE. Held clear keeps it there.
- **Leaving COOK:**
  - stopn==0 or door open in COOK → PAUSED, time frozen.
- **Entering COOK:**
  - From IDLE or PAUSED: startn==0, stopn==1, door_closed==1 and time ≠ 0:00 → COOK.
  - Because start is level-sensitive, releasing stopn while startn is still low resumes cooking.
  - Entering COOK clears the prescaler.
- **Countdown (COOK):**
  - Prescaler counts 0..CLK_HZ-1. On wrap (tick), time decrements by one second.
  - Borrow rules:
    - O>0 → O-1.
    - O=0, T>0 → T-1, O=9.
    - O=T=0, M>0 → M-1, T=5, O=9.
  - An entered T above 5 counts down normally.
  - When the decrement produces 0:00, state → IDLE on the same edge.
- **Display:**
  - Combinational decode of each BCD digit, active-high, bit0=a … bit6=g.
  - Codes: 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Displays track the register in every state.

## Timing
- mag_on is registered as (next state == COOK):
  - It rises on the edge that samples a valid start.
  - It falls on the edge that samples stop, door open, clear, reset or expiry.
- First decrement occurs exactly CLK_HZ cycles after the edge entering COOK. Later decrements occur every CLK_HZ cycles.
- PAUSED→COOK restarts the prescaler from 0. A partial second is not carried.
- A key press is visible on the displays the cycle after the accepting edge.
- Start with 0:00 is ignored; state stays IDLE and mag_on stays 0.
- Start with door open is ignored until door_closed rises while startn is still low.

## Test plan
- **Reset:** reset=1 for 2 cycles → all displays 7'h3F, mag_on=0, state IDLE.
- **Entry:** keys 1, 4, 0, each held 50 cycles with 50 idle cycles between → mins=06, sec_tens=66, sec_ones=3F. An invalid pattern 10'b10_0001_0000 leaves the time unchanged.
- **Countdown:** from 1:40, door_closed=1, startn=0 → mag_on rises next edge; after 1000 cycles time = 1:30.
- **Pause/resume:** stopn=0 at 1:30 for 500 cycles → mag_on=0, time frozen at 1:30. Release stopn with startn still low → resumes; 1:29 appears after 100 more cycles.
- **Clear:** clearn=0 for 20 cycles mid-cook → mag_on=0, display 0:00, IDLE. Keys 1, 4, 0 then re-start → cooks again from 1:40.
- **Expiry/interlock:**
  - Enter 0:02 and start → 0:00 after 200 cycles, mag_on falls the same edge.
  - Opening the door during cook → PAUSED with time held.
  - Start with 0:00 → mag_on stays 0.
